// File: rtl/home_auto_pkg.sv
// Shared home-automation types: appliance slot states, appliance indices, default priority class.
package home_auto_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    RUN      = 2'd2,
    COOLDOWN = 2'd3
  } slot_state_t;

  localparam int unsigned FRIDGE       = 0;
  localparam int unsigned OVEN         = 1;
  localparam int unsigned COFFEE_MAKER = 2;
  localparam int unsigned WASHER       = 3;
  localparam int unsigned DISHWASHER   = 4;

  localparam int unsigned N_APPL_DEFAULT    = 5;
  localparam logic [4:0]  PRIO_MASK_DEFAULT = 5'b00001;

endpackage

// File: rtl/appliance_slot.sv
// Per-appliance slot: request/grant FSM with saturating minimum-on and cooldown counters.
module appliance_slot
  import home_auto_pkg::*;
#(
  parameter int unsigned MIN_ON_CYCLES   = 16,
  parameter int unsigned COOLDOWN_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        grant,
  output logic        cmd,
  output logic        waiting,
  output logic        run_next,
  output slot_state_t state
);

  localparam int unsigned ON_W = (MIN_ON_CYCLES > 1) ? $clog2(MIN_ON_CYCLES) : 1;
  localparam int unsigned CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [ON_W-1:0] ON_MAX = ON_W'(MIN_ON_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_MAX = CD_W'(COOLDOWN_CYCLES - 1);

  slot_state_t     state_q, state_d;
  logic [ON_W-1:0] on_q, on_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            cmd_q, cmd_d;
  logic            waiting_q, waiting_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      on_q      <= '0;
      cd_q      <= '0;
      cmd_q     <= 1'b0;
      waiting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      on_q      <= on_d;
      cd_q      <= cd_d;
      cmd_q     <= cmd_d;
      waiting_q <= waiting_d;
    end
  end

  // A withdrawn request beats a same-cycle grant; the arbiter masks such slots anyway.
  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    cd_d    = cd_q;
    case (state_q)
      IDLE: begin
        if (req) state_d = WAIT;
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (grant) begin
          state_d = RUN;
          on_d    = '0;
        end
      end
      RUN: begin
        if (on_q < ON_MAX) on_d = on_q + ON_W'(1);
        if (!req && (on_q >= ON_MAX)) begin
          state_d = COOLDOWN;
          cd_d    = '0;
        end
      end
      COOLDOWN: begin
        if (cd_q >= CD_MAX) state_d = IDLE;
        else                cd_d    = cd_q + CD_W'(1);
      end
      default: state_d = IDLE;
    endcase
    cmd_d     = (state_d == RUN);
    waiting_d = (state_d == WAIT);
  end

  assign cmd      = cmd_q;
  assign waiting  = waiting_q;
  assign run_next = cmd_d;
  assign state    = state_q;

endmodule

// File: rtl/appliance_load_scheduler.sv
// Power-budget scheduler: N appliance slots, priority-then-round-robin arbiter, registered popcount.
module appliance_load_scheduler
  import home_auto_pkg::*;
#(
  parameter int unsigned       N_APPL          = N_APPL_DEFAULT,
  parameter int unsigned       MAX_ACTIVE      = 2,
  parameter int unsigned       MIN_ON_CYCLES   = 16,
  parameter int unsigned       COOLDOWN_CYCLES = 8,
  parameter logic [N_APPL-1:0] PRIO_MASK       = N_APPL'(PRIO_MASK_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_APPL-1:0]             req,
  output logic [N_APPL-1:0]             cmd,
  output logic [N_APPL-1:0]             waiting,
  output logic [$clog2(N_APPL+1)-1:0]   active_count,
  output logic                          budget_full
);

  localparam int unsigned CNT_W = $clog2(N_APPL + 1);
  localparam int unsigned IDX_W = (N_APPL > 1) ? $clog2(N_APPL) : 1;

  slot_state_t       slot_state [N_APPL];
  logic [N_APPL-1:0] run_next;
  logic [N_APPL-1:0] cand;
  logic [N_APPL-1:0] prio_cand;
  logic [N_APPL-1:0] grant;
  logic              found;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  active_count_q, count_d;
  logic              budget_full_q;

  for (genvar g = 0; g < N_APPL; g++) begin : g_slot
    appliance_slot #(
      .MIN_ON_CYCLES  (MIN_ON_CYCLES),
      .COOLDOWN_CYCLES(COOLDOWN_CYCLES)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .req     (req[g]),
      .grant   (grant[g]),
      .cmd     (cmd[g]),
      .waiting (waiting[g]),
      .run_next(run_next[g]),
      .state   (slot_state[g])
    );
  end

  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < N_APPL; i++) begin
      cand[i] = (slot_state[i] == WAIT) && req[i];
    end
    prio_cand = cand & PRIO_MASK;
  end

  // One grant per cycle, gated by the registered count so a same-cycle release frees budget next cycle.
  always_comb begin
    int unsigned idx;
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = 0;
    if (active_count_q < CNT_W'(MAX_ACTIVE)) begin
      if (|prio_cand) begin
        for (int unsigned i = 0; i < N_APPL; i++) begin
          if (prio_cand[i] && !found) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end else begin
        for (int unsigned k = 1; k <= N_APPL; k++) begin
          idx = (32'(rr_ptr_q) + k) % N_APPL;
          if (cand[IDX_W'(idx)] && !found) begin
            grant[IDX_W'(idx)] = 1'b1;
            rr_ptr_d           = IDX_W'(idx);
            found              = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < N_APPL; i++) begin
      count_d = count_d + CNT_W'(run_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q       <= IDX_W'(N_APPL - 1);
      active_count_q <= '0;
      budget_full_q  <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      active_count_q <= count_d;
      budget_full_q  <= (count_d == CNT_W'(MAX_ACTIVE));
    end
  end

  assign active_count = active_count_q;
  assign budget_full  = budget_full_q;

endmodule

// File: tb/tb_appliance_load_scheduler.sv
// Directed bench for appliance_load_scheduler: vector table plus async-reset and fairness sequences.
module tb_appliance_load_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = '0;
  logic [4:0] cmd, waiting;
  logic [2:0] cnt;
  logic       full;

  logic [4:0] req_b = '0;
  logic [4:0] cmd_b, waiting_b;
  logic [2:0] cnt_b;
  logic       full_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  appliance_load_scheduler u_dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .cmd         (cmd),
    .waiting     (waiting),
    .active_count(cnt),
    .budget_full (full)
  );

  // Single-slot budget with one-cycle minimum-on, used for the rotation check.
  appliance_load_scheduler #(
    .MAX_ACTIVE   (1),
    .MIN_ON_CYCLES(1)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .req         (req_b),
    .cmd         (cmd_b),
    .waiting     (waiting_b),
    .active_count(cnt_b),
    .budget_full (full_b)
  );

  typedef struct {
    logic       do_rst;
    logic [4:0] req;
    int         n;
    logic [4:0] cmd;
    logic [4:0] wt;
    logic [2:0] cnt;
    logic       full;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [4:0] rq, input int n,
                     input logic [4:0] c, input logic [4:0] w, input logic [2:0] k,
                     input logic f);
    vec_t v;
    v.do_rst = r; v.req = rq; v.n = n; v.cmd = c; v.wt = w; v.cnt = k; v.full = f;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_a(input string name, input logic [4:0] ec, input logic [4:0] ew,
                         input logic [2:0] en, input logic ef);
    checks++;
    if ({cmd, waiting, cnt, full} !== {ec, ew, en, ef}) begin
      errors++;
      $display("FAIL %s: got cmd=%b waiting=%b count=%0d full=%b, want cmd=%b waiting=%b count=%0d full=%b",
               name, cmd, waiting, cnt, full, ec, ew, en, ef);
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    req   = '0;
    req_b = '0;
    @(negedge clk);
    check_a("reset", 5'b0, 5'b0, 3'd0, 1'b0);
    cmp("reset_b", {cmd_b, waiting_b, cnt_b, full_b}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    // Single request, release after the minimum, cooldown blocking a re-request.
    add(1, 5'b00000, 0,  5'b00000, 5'b00000, 0, 0);
    add(0, 5'b00100, 1,  5'b00000, 5'b00100, 0, 0);
    add(0, 5'b00100, 1,  5'b00100, 5'b00000, 1, 0);
    add(0, 5'b00100, 28, 5'b00100, 5'b00000, 1, 0);
    add(0, 5'b00000, 1,  5'b00000, 5'b00000, 0, 0);
    add(0, 5'b00100, 8,  5'b00000, 5'b00000, 0, 0);
    add(0, 5'b00100, 1,  5'b00000, 5'b00100, 0, 0);
    add(0, 5'b00100, 1,  5'b00100, 5'b00000, 1, 0);
    add(0, 5'b00000, 15, 5'b00100, 5'b00000, 1, 0);
    add(0, 5'b00000, 1,  5'b00000, 5'b00000, 0, 0);
    add(0, 5'b00000, 8,  5'b00000, 5'b00000, 0, 0);
    // Oven 3-cycle pulse: 16 cycles on, then a request during cooldown waits for IDLE.
    add(0, 5'b00010, 1,  5'b00000, 5'b00010, 0, 0);
    add(0, 5'b00010, 1,  5'b00010, 5'b00000, 1, 0);
    add(0, 5'b00010, 1,  5'b00010, 5'b00000, 1, 0);
    add(0, 5'b00000, 14, 5'b00010, 5'b00000, 1, 0);
    add(0, 5'b00000, 1,  5'b00000, 5'b00000, 0, 0);
    add(0, 5'b00010, 7,  5'b00000, 5'b00000, 0, 0);
    add(0, 5'b00010, 1,  5'b00000, 5'b00000, 0, 0);
    add(0, 5'b00010, 1,  5'b00000, 5'b00010, 0, 0);
    add(0, 5'b00010, 1,  5'b00010, 5'b00000, 1, 0);
    add(0, 5'b00000, 15, 5'b00010, 5'b00000, 1, 0);
    add(0, 5'b00000, 1,  5'b00000, 5'b00000, 0, 0);
    add(0, 5'b00000, 8,  5'b00000, 5'b00000, 0, 0);
    // Budget limit, round-robin, fridge priority, withdrawal.
    add(1, 5'b00000, 0,  5'b00000, 5'b00000, 0, 0);
    add(0, 5'b11110, 1,  5'b00000, 5'b11110, 0, 0);
    add(0, 5'b11110, 1,  5'b00010, 5'b11100, 1, 0);
    add(0, 5'b11110, 1,  5'b00110, 5'b11000, 2, 1);
    add(0, 5'b11110, 15, 5'b00110, 5'b11000, 2, 1);
    add(0, 5'b11100, 1,  5'b00100, 5'b11000, 1, 0);
    add(0, 5'b11100, 1,  5'b01100, 5'b10000, 2, 1);
    add(0, 5'b11101, 1,  5'b01100, 5'b10001, 2, 1);
    add(0, 5'b11001, 1,  5'b01000, 5'b10001, 1, 0);
    add(0, 5'b11001, 1,  5'b01001, 5'b10000, 2, 1);
    add(0, 5'b10001, 12, 5'b01001, 5'b10000, 2, 1);
    add(0, 5'b10001, 1,  5'b00001, 5'b10000, 1, 0);
    add(0, 5'b10001, 1,  5'b10001, 5'b00000, 2, 1);
    add(0, 5'b10011, 1,  5'b10001, 5'b00010, 2, 1);
    add(0, 5'b10001, 1,  5'b10001, 5'b00000, 2, 1);
    add(0, 5'b00000, 1,  5'b10000, 5'b00000, 1, 0);
    add(0, 5'b00000, 12, 5'b10000, 5'b00000, 1, 0);
    add(0, 5'b00000, 1,  5'b00000, 5'b00000, 0, 0);
    add(0, 5'b00000, 9,  5'b00000, 5'b00000, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) begin
        do_reset();
      end else begin
        req = tbl[i].req;
        for (int j = 0; j < tbl[i].n; j++) begin
          tick();
          check_a($sformatf("row%0d.%0d", i, j), tbl[i].cmd, tbl[i].wt, tbl[i].cnt, tbl[i].full);
        end
      end
    end

    // Async reset while fridge and coffee maker run, then re-arbitration from appliance 0.
    do_reset();
    req = 5'b00101;
    tick(); check_a("ar_wait",  5'b00000, 5'b00101, 3'd0, 1'b0);
    tick(); check_a("ar_grant0", 5'b00001, 5'b00100, 3'd1, 1'b0);
    tick(); check_a("ar_grant2", 5'b00101, 5'b00000, 3'd2, 1'b1);
    #2 rst = 1'b1;
    #1 check_a("ar_async", 5'b00000, 5'b00000, 3'd0, 1'b0);
    req = 5'b01010;
    @(negedge clk);
    rst = 1'b0;
    tick(); check_a("ar_rewait",  5'b00000, 5'b01010, 3'd0, 1'b0);
    tick(); check_a("ar_regrant1", 5'b00010, 5'b01000, 3'd1, 1'b0);
    tick(); check_a("ar_regrant3", 5'b01010, 5'b00000, 3'd2, 1'b1);

    // Rotation with one slot of budget: fridge first, then 1..4, each dropping its request once granted.
    do_reset();
    begin
      int k;
      k = 0;
      req_b = 5'b11111;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (cmd_b != 5'b0) begin
          cmp($sformatf("rot_grant%0d", k), 32'(cmd_b), (k < 5) ? (32'd1 << k) : 32'd0);
          cmp($sformatf("rot_count%0d", k), {30'd0, cnt_b[1:0]} | {31'd0, full_b} << 2, 32'd5);
          req_b = req_b & ~cmd_b;
          k++;
        end
      end
      cmp("rot_total", 32'(k), 32'd5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
